// File: rtl/md_div_unit.sv
// Iterative M-extension divider: DIV/DIVU/REM/REMU plus word forms.
// Optional MD_DIV_EARLY_OUT_EN skips the dividend's leading-zero iterations.
package md_div_pkg;
  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7
  } md_op_t;

  typedef enum logic [2:0] {
    DS_NONE          = 3'd0,
    DS_ZERO_DIVISOR  = 3'd1,
    DS_OVERFLOW      = 3'd2,
    DS_ZERO_DIVIDEND = 3'd3,
    DS_SHORT_DIV     = 3'd4
  } div_status_t;
endpackage

module md_div_unit
  import md_div_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic            req_word_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [2:0]      resp_status
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int LK = $clog2(K);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_FIX, S_DONE
  } state_t;

  state_t          state_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  div_status_t     resp_status_q;
  logic [XLEN-1:0] a_q, r_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            negq_q, negr_q, rem_q, word_q;

  function automatic logic [XLEN-1:0] fit(
    input logic [XLEN-1:0] v,
    input logic            w
  );
    logic [XLEN-1:0] o;
    o = v;
    if (w)
      for (int i = 32; i < XLEN; i++) o[i] = v[31];
    return o;
  endfunction

  logic            legal, sgn, is_rem;
  logic            s1, s2, ovf, spec;
  logic [XLEN-1:0] x1, x2, m1, m2, al;
  logic [XLEN-1:0] minneg, ones, spec_res;
  div_status_t     spec_st;
  logic [CW-1:0]   wid, lz, iters, cnt_ld;

  always_comb begin
    legal = (req_op[3:2] == 2'b01);
    is_rem = req_op[1];
    sgn = ~req_op[0];
    x1 = req_op1;
    x2 = req_op2;
    if (req_word_op) begin
      x1 = XLEN'(req_op1[31:0]);
      x2 = XLEN'(req_op2[31:0]);
    end
    s1 = sgn & (req_word_op ? req_op1[31] : req_op1[XLEN-1]);
    s2 = sgn & (req_word_op ? req_op2[31] : req_op2[XLEN-1]);
    m1 = s1 ? ~x1 + 1'b1 : x1;
    m2 = s2 ? ~x2 + 1'b1 : x2;
    if (req_word_op) begin
      m1 = XLEN'(m1[31:0]);
      m2 = XLEN'(m2[31:0]);
    end
    minneg = req_word_op ? XLEN'(32'h8000_0000)
                         : {1'b1, {(XLEN-1){1'b0}}};
    ones = req_word_op ? XLEN'(32'hFFFF_FFFF) : '1;
    ovf = sgn & (x1 == minneg) & (x2 == ones);
    wid = req_word_op ? CW'(32) : CW'(XLEN);
    // Align the dividend MSB to the top of the shift register.
    al = req_word_op ? (m1 << (XLEN - 32)) : m1;
  end

  always_comb begin
    spec = 1'b1;
    spec_st = DS_NONE;
    spec_res = '0;
    if (!legal) begin
      spec_res = '0;
    end else if (x2 == '0) begin
      spec_st = DS_ZERO_DIVISOR;
      spec_res = is_rem ? x1 : '1;
    end else if (ovf) begin
      spec_st = DS_OVERFLOW;
      spec_res = is_rem ? '0 : x1;
    end else if (x1 == '0) begin
      spec_st = DS_ZERO_DIVIDEND;
    end else if (m2 > m1) begin
      spec_st = DS_SHORT_DIV;
      spec_res = is_rem ? x1 : '0;
    end else begin
      spec = 1'b0;
    end
  end

`ifdef MD_DIV_EARLY_OUT_EN
  always_comb begin
    lz = '0;
    for (int i = 0; i < XLEN; i++)
      if (al[i]) lz = CW'(XLEN - 1 - i);
    lz = lz & ~CW'(K - 1);
  end
`else
  assign lz = '0;
`endif

  assign iters  = (wid - lz) >> LK;
  assign cnt_ld = (iters == '0) ? '0 : iters - 1'b1;

  logic [XLEN-1:0] a_n, r_n;
  logic [XLEN:0]   t;

  always_comb begin
    a_n = a_q;
    r_n = r_q;
    t = '0;
    for (int k = 0; k < K; k++) begin
      t = {r_n, a_n[XLEN-1]};
      a_n = a_n << 1;
      if (t >= {1'b0, dvs_q}) begin
        r_n = XLEN'(t - {1'b0, dvs_q});
        a_n[0] = 1'b1;
      end else begin
        r_n = t[XLEN-1:0];
      end
    end
  end

  logic [XLEN-1:0] q_f, r_f, fix_res;

  always_comb begin
    q_f = word_q ? XLEN'(a_q[31:0]) : a_q;
    if (negq_q) q_f = ~q_f + 1'b1;
    r_f = negr_q ? ~r_q + 1'b1 : r_q;
    fix_res = fit(rem_q ? r_f : q_f, word_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= DS_NONE;
      a_q           <= '0;
      r_q           <= '0;
      dvs_q         <= '0;
      cnt_q         <= '0;
      negq_q        <= 1'b0;
      negr_q        <= 1'b0;
      rem_q         <= 1'b0;
      word_q        <= 1'b0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          req_ready_q <= 1'b0;
          rem_q       <= is_rem;
          word_q      <= req_word_op;
          negq_q      <= s1 ^ s2;
          negr_q      <= s1;
          if (spec) begin
            state_q       <= S_DONE;
            resp_valid_q  <= 1'b1;
            resp_data_q   <= fit(spec_res, req_word_op);
            resp_status_q <= spec_st;
          end else begin
            state_q <= S_CALC;
            a_q     <= al << lz;
            r_q     <= '0;
            dvs_q   <= m2;
            cnt_q   <= cnt_ld;
          end
        end
        S_CALC: begin
          a_q <= a_n;
          r_q <= r_n;
          if (cnt_q == '0) state_q <= S_FIX;
          else cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          state_q       <= S_DONE;
          resp_valid_q  <= 1'b1;
          resp_data_q   <= fix_res;
          resp_status_q <= DS_NONE;
        end
        S_DONE: if (resp_ready) begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;

endmodule

// File: tb/tb_md_div_unit.sv
// Directed bench for md_div_unit: XLEN=64 with K=1 and K=4 instances.
// Table vectors plus flush, backpressure and mid-op reset sequences.
module tb_md_div_unit;

  logic        clk = 1'b0;
  logic        resetn, flush, req_valid, resp_ready, req_word_op;
  logic [3:0]  req_op;
  logic [63:0] req_op1, req_op2;
  logic        rdy1, val1, rdy4, val4;
  logic [63:0] data1, data4;
  logic [2:0]  st1, st4;

  always #5 clk = ~clk;

  md_div_unit #(.XLEN(64), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_op(req_op), .req_word_op(req_word_op),
    .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(val1), .resp_ready(resp_ready),
    .resp_data(data1), .resp_status(st1)
  );

  md_div_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(rdy4),
    .req_op(req_op), .req_word_op(req_word_op),
    .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(val4), .resp_ready(resp_ready),
    .resp_data(data4), .resp_status(st4)
  );

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [2:0]  st;
    int          lat1;
    int          lat4;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;

  function automatic vec_t mk(string nm, logic [3:0] op, logic w,
                              logic [63:0] a, logic [63:0] b,
                              logic [63:0] exp, logic [2:0] st,
                              int lat1, int lat4);
    vec_t v;
    v.nm = nm; v.op = op; v.w = w; v.a = a; v.b = b;
    v.exp = exp; v.st = st; v.lat1 = lat1; v.lat4 = lat4;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] op, logic w,
                       logic [63:0] a, logic [63:0] b);
    req_op = op; req_word_op = w; req_op1 = a; req_op2 = b;
    req_valid = 1'b1;
  endtask

  task automatic run(input vec_t v);
    int c1, c4, cyc, wt;
    logic [63:0] d1, d4;
    logic [2:0]  s1, s4;
    c1 = -1; c4 = -1; d1 = '0; d4 = '0; s1 = '0; s4 = '0;
    @(negedge clk);
    resp_ready = 1'b1;
    wt = 0;
    while (!(rdy1 && rdy4) && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    chk($sformatf("%s ready", v.nm), {62'd0, rdy1, rdy4}, 64'd3);
    drive(v.op, v.w, v.a, v.b);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while ((c1 < 0 || c4 < 0) && cyc < 200) begin
      if (c1 < 0 && val1) begin c1 = cyc; d1 = data1; s1 = st1; end
      if (c4 < 0 && val4) begin c4 = cyc; d4 = data4; s4 = st4; end
      if (c1 < 0 || c4 < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk($sformatf("%s data k1", v.nm), d1, v.exp);
    chk($sformatf("%s stat k1", v.nm), 64'(s1), 64'(v.st));
    chk($sformatf("%s lat k1", v.nm), 64'(c1), 64'(v.lat1));
    chk($sformatf("%s data k4", v.nm), d4, v.exp);
    chk($sformatf("%s stat k4", v.nm), 64'(s4), 64'(v.st));
    chk($sformatf("%s lat k4", v.nm), 64'(c4), 64'(v.lat4));
  endtask

  initial begin
    bit seen;
    tv.push_back(mk("div_m7_2", 4, 0, M7, 2,
                    64'hFFFF_FFFF_FFFF_FFFD, 0, 66, 18));
    tv.push_back(mk("rem_m7_2", 6, 0, M7, 2, ALL1, 0, 66, 18));
    tv.push_back(mk("divu_by0", 5, 0, 64'h1234, 0, ALL1, 1, 1, 1));
    tv.push_back(mk("remu_by0", 7, 0, 64'h1234, 0, 64'h1234, 1, 1, 1));
    tv.push_back(mk("divw_ovf", 4, 1, 64'h8000_0000, 64'hFFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000, 2, 1, 1));
    tv.push_back(mk("remw_ovf", 6, 1, 64'h8000_0000, 64'hFFFF_FFFF,
                    0, 2, 1, 1));
    tv.push_back(mk("divuw_big", 5, 1, 64'hFFFF_FFFE, 1,
                    64'hFFFF_FFFF_FFFF_FFFE, 0, 34, 10));
    tv.push_back(mk("remu_short", 7, 0, 5, 9, 5, 4, 1, 1));
    tv.push_back(mk("remu_zdvd", 7, 0, 0, 9, 0, 3, 1, 1));
    tv.push_back(mk("illegal_op", 2, 0, 5, 3, 0, 0, 1, 1));
    tv.push_back(mk("div_ovf64", 4, 0, 64'h8000_0000_0000_0000, ALL1,
                    64'h8000_0000_0000_0000, 2, 1, 1));
    tv.push_back(mk("div_100_m7", 4, 0, 100, M7,
                    64'hFFFF_FFFF_FFFF_FFF2, 0, 66, 18));
    tv.push_back(mk("rem_100_m7", 6, 0, 100, M7, 2, 0, 66, 18));
    tv.push_back(mk("remw_junk", 6, 1, 64'h1234_5678_FFFF_FFF9, 2,
                    ALL1, 0, 34, 10));
    tv.push_back(mk("divuw_junk", 5, 1, 64'h1234_5678_0000_0064,
                    64'hFFFF_0000_0000_0007, 14, 0, 34, 10));
    tv.push_back(mk("rem_short_neg", 6, 0, 64'hFFFF_FFFF_FFFF_FFFD, 5,
                    64'hFFFF_FFFF_FFFF_FFFD, 4, 1, 1));
    tv.push_back(mk("divu_max", 5, 0, ALL1, 1, ALL1, 0, 66, 18));
    tv.push_back(mk("divu_0by0", 5, 0, 0, 0, ALL1, 1, 1, 1));
    tv.push_back(mk("divu_eq", 5, 0, 7, 7, 1, 0, 66, 18));
    tv.push_back(mk("divuw_half", 5, 1, 64'h8000_0000, 2,
                    64'h4000_0000, 0, 34, 10));
    tv.push_back(mk("remuw_by0", 7, 1, 64'hFFFF_FFFF, 0, ALL1, 1, 1, 1));

    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_op = '0; req_word_op = 1'b0; req_op1 = '0; req_op2 = '0;
    #12;
    chk("rst ready", 64'(rdy1), 64'd1);
    chk("rst valid", 64'(val1), 64'd0);
    chk("rst data", data1, 64'd0);
    chk("rst status", 64'(st1), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tv[i]) run(tv[i]);

    // Flush mid-CALC: nothing may come back from the killed request.
    @(negedge clk);
    drive(4'd5, 1'b0, 64'd1000, 64'd3);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("calc busy", {62'd0, rdy1, rdy4}, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush ready", {62'd0, rdy1, rdy4}, 64'd3);
    chk("flush valid", {62'd0, val1, val4}, 64'd0);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (val1 || val4) seen = 1'b1;
    end
    chk("flush silent", 64'(seen), 64'd0);

    // Flush beats a request presented in IDLE.
    @(negedge clk);
    drive(4'd5, 1'b0, 64'h55, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    chk("idle flush ready", {62'd0, rdy1, rdy4}, 64'd3);
    chk("idle flush valid", {62'd0, val1, val4}, 64'd0);

    run(mk("after_flush", 5, 0, 100, 7, 14, 0, 66, 18));

    // Backpressure: result held, no new request accepted.
    @(negedge clk);
    resp_ready = 1'b0;
    drive(4'd5, 1'b0, 64'h1234, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp valid", {62'd0, val1, val4}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp data %0d", i), data1, ALL1);
      chk($sformatf("bp stat %0d", i), 64'(st1), 64'd1);
      chk($sformatf("bp ready %0d", i), {62'd0, rdy1, rdy4}, 64'd0);
      chk($sformatf("bp hold %0d", i), {62'd0, val1, val4}, 64'd3);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", {62'd0, val1, val4}, 64'd0);
    chk("bp release ready", {62'd0, rdy1, rdy4}, 64'd3);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive(4'd5, 1'b0, 64'd1000, 64'd3);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid rst ready", {62'd0, rdy1, rdy4}, 64'd3);
    chk("mid rst valid", {62'd0, val1, val4}, 64'd0);
    chk("mid rst data", data1, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run(mk("after_rst", 5, 0, 1000, 3, 333, 0, 66, 18));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_div_unit.md
Name: md_div_unit

Overview:
- Parametrised iterative integer divider for the M-extension execute path.
- Handles OP_DIV, OP_DIVU, OP_REM and OP_REMU (md_op_t encodings 4..7) at XLEN width, plus the 32-bit word forms (DIVW/DIVUW/REMW/REMUW) selected by word_op.
- Retires a configurable number of quotient bits per cycle.
- Classifies special operands into the div_status_t codes and resolves them without iterating.
- Sits beside the multiplier in the EXU, with a valid/ready handshake on both sides.

Parameters:
- XLEN, 64, operand/result width; must be 32 or 64.
- BITS_PER_CYCLE, 1, quotient bits retired per CALC cycle; must be 1, 2 or 4 and divide 32.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  kill the in-flight operation; unit returns to IDLE next edge.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_op  in  4  md_op_t; only OP_DIV..OP_REMU are legal.
- req_word_op  in  1  32-bit word operation.
- req_op1  in  XLEN  dividend.
- req_op2  in  XLEN  divisor.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  quotient or remainder, per req_op.
- resp_status  out  3  div_status_t: NONE=0, ZERO_DIVISOR=1, OVERFLOW=2, ZERO_DIVIDEND=3, SHORT_DIV=4.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_status=NONE.
- Reset asserted mid-operation discards the operation silently.
- States: IDLE, CALC, FIX, DONE.
- IDLE, request accepted (req_valid & req_ready):
  - Capture the operands.
  - W=32 if word_op, else XLEN.
  - Word ops use op[31:0] only; signed word ops sign-interpret bit 31.
  - Signed ops: latch the sign of each operand, then take magnitudes.
- Special-case classification, in priority order:
  - ZERO_DIVISOR: divisor==0. Quotient = all ones; remainder = dividend.
  - OVERFLOW: signed op, dividend == most-negative W-bit value, divisor == -1. Quotient = dividend; remainder = 0.
  - ZERO_DIVIDEND: dividend==0. Quotient = 0; remainder = 0.
  - SHORT_DIV: |divisor| > |dividend| (unsigned magnitude compare). Quotient = 0; remainder = dividend.
  - Any special case goes IDLE->DONE. resp_valid is high 1 cycle after acceptance.
- Normal path, IDLE->CALC:
  - Restoring division on magnitudes, retiring BITS_PER_CYCLE bits per cycle.
  - Stays in CALC for exactly W/BITS_PER_CYCLE cycles, counted by an iteration counter.
  - Then FIX for 1 cycle:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Then DONE with resp_status=NONE.
  - resp_valid is high W/BITS_PER_CYCLE+2 cycles after acceptance.
- Word ops: the 32-bit result is sign-extended to XLEN (bit 31 replicated), including unsigned word ops. Special-case results are sign-extended the same way.
- DONE:
  - resp_valid=1. resp_data and resp_status are held stable until resp_valid & resp_ready.
  - Handshake completes -> IDLE; req_ready rises the following cycle. There is no same-cycle re-accept.
- Illegal req_op (not 4..7): accepted, goes to DONE in 1 cycle with resp_data=0, status=NONE.
- flush:
  - In CALC, FIX or DONE: next state is IDLE, resp_valid drops, nothing is reported.
  - In IDLE together with req_valid: the request is not accepted. flush has priority.
- req_ready is 0 in every state except IDLE.

Optional Feature:
- Macro: MD_DIV_EARLY_OUT_EN.
- Defined:
  - On acceptance, count leading zeros of the dividend magnitude, rounded down to a multiple of BITS_PER_CYCLE.
  - Pre-shift the dividend by that count.
  - CALC lasts (W - lz)/BITS_PER_CYCLE cycles, minimum 1.
  - Results are identical to the non-early-out build.
- Undefined: CALC is always W/BITS_PER_CYCLE cycles; no leading-zero logic is instantiated.

Test Plan:
- XLEN=64, K=1, OP_DIV, op1=-7, op2=2, resp_ready=1 -> resp_data=-3, status NONE, resp_valid exactly 66 cycles after acceptance; OP_REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- OP_DIVU, op2=0, op1=0x1234 -> resp_data=0xFFFF_FFFF_FFFF_FFFF, status ZERO_DIVISOR, latency 1; OP_REMU on the same operands -> 0x1234.
- OP_DIV, word_op=1, op1=0x8000_0000, op2=0xFFFF_FFFF -> resp_data=0xFFFF_FFFF_8000_0000, status OVERFLOW; OP_REM -> 0.
- OP_DIVU, word_op=1, op1=0xFFFF_FFFE, op2=1 -> resp_data=0xFFFF_FFFF_FFFF_FFFE, latency 34 (K=1); with K=4 latency 10.
- OP_REMU, op1=5, op2=9 -> status SHORT_DIV, resp_data=5; op1=0 -> status ZERO_DIVIDEND, resp_data=0.
- Mid-CALC flush, then a new request op1=100, op2=7 OP_DIVU -> no response for the first request, second returns 14; resp_ready held low 5 cycles -> resp_data stable and req_ready=0 throughout.
